// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS front-end pipeline registers.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_occ_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_beat_t;

endpackage

// File: rtl/ifid_entry_reg.sv
// One IF/ID storage slot: instruction, PC and precomputed PC+4, loaded on enable.
module ifid_entry_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [PC_W-1:0]    d_pc_plus4,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (load) begin
      instr    <= d_instr;
      pc       <= d_pc;
      pc_plus4 <= d_pc_plus4;
    end
  end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF->ID pipeline register with valid/ready handshake, flush, optional 2-entry skid
// buffer (registered if_ready) and a saturating bubble counter.
module ifid_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_WORD),
  parameter bit                 SKID_EN   = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ifid_occ_t          state;
  logic               acc, pop;
  logic               main_load, skid_load, main_from_skid;
  logic [PC_W-1:0]    in_pc_plus4;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_d_instr;
  logic [PC_W-1:0]    main_pc, skid_pc, main_d_pc;
  logic [PC_W-1:0]    main_pc_plus4, skid_pc_plus4, main_d_pc_plus4;

  assign id_valid = (state != EMPTY);
  // With the skid slot, ready comes from registered state only; without it the
  // single slot can refill in the same edge it is drained.
  assign if_ready = SKID_EN ? (state != TWO) : ((state == EMPTY) || id_ready);
  assign acc      = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

  // The adder sits on the load path so id_pc_plus4 comes straight from a flop.
  assign in_pc_plus4 = if_pc + PC_W'(4);

  always_comb begin
    main_from_skid = (state == TWO);
    main_load      = 1'b0;
    skid_load      = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY:   main_load = acc;
        ONE: begin
          main_load = acc && pop;
          skid_load = SKID_EN && acc && !pop;
        end
        TWO:     main_load = pop;
        default: main_load = 1'b0;
      endcase
    end
    main_d_instr    = main_from_skid ? skid_instr    : if_instr;
    main_d_pc       = main_from_skid ? skid_pc       : if_pc;
    main_d_pc_plus4 = main_from_skid ? skid_pc_plus4 : in_pc_plus4;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) state <= ONE;
        ONE: begin
          if (acc && !pop)      state <= TWO;
          else if (!acc && pop) state <= EMPTY;
        end
        TWO:     if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!id_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  ifid_entry_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clock      (clock),
    .reset      (reset),
    .load       (main_load),
    .d_instr    (main_d_instr),
    .d_pc       (main_d_pc),
    .d_pc_plus4 (main_d_pc_plus4),
    .instr      (main_instr),
    .pc         (main_pc),
    .pc_plus4   (main_pc_plus4)
  );

  generate
    if (SKID_EN) begin : g_skid
      ifid_entry_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clock      (clock),
        .reset      (reset),
        .load       (skid_load),
        .d_instr    (if_instr),
        .d_pc       (if_pc),
        .d_pc_plus4 (in_pc_plus4),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .pc_plus4   (skid_pc_plus4)
      );
    end else begin : g_no_skid
      assign skid_instr    = NOP_INSTR;
      assign skid_pc       = '0;
      assign skid_pc_plus4 = '0;
    end
  endgenerate

  assign id_instr    = id_valid ? main_instr    : NOP_INSTR;
  assign id_pc       = id_valid ? main_pc       : '0;
  assign id_pc_plus4 = id_valid ? main_pc_plus4 : '0;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench: skid-buffered instance (default params) and a single-entry
// instance with a 2-bit bubble counter, sharing clock and reset.
module tb_ifid_skid_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        a_if_valid = 1'b0, a_if_ready, a_flush = 1'b0, a_id_valid, a_id_ready = 1'b0;
  logic [31:0] a_if_instr = '0, a_if_pc = '0, a_id_instr, a_id_pc, a_id_pc_plus4;
  logic [15:0] a_bubble;

  logic        b_if_valid = 1'b0, b_if_ready, b_flush = 1'b0, b_id_valid, b_id_ready = 1'b0;
  logic [31:0] b_if_instr = '0, b_if_pc = '0, b_id_instr, b_id_pc, b_id_pc_plus4;
  logic [1:0]  b_bubble;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ifid_skid_stage dut_a (
    .clock(clock), .reset(reset),
    .if_valid(a_if_valid), .if_ready(a_if_ready), .if_instr(a_if_instr), .if_pc(a_if_pc),
    .flush(a_flush),
    .id_valid(a_id_valid), .id_ready(a_id_ready), .id_instr(a_id_instr),
    .id_pc(a_id_pc), .id_pc_plus4(a_id_pc_plus4), .bubble_cnt(a_bubble)
  );

  ifid_skid_stage #(.SKID_EN(1'b0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset),
    .if_valid(b_if_valid), .if_ready(b_if_ready), .if_instr(b_if_instr), .if_pc(b_if_pc),
    .flush(b_flush),
    .id_valid(b_id_valid), .id_ready(b_id_ready), .id_instr(b_id_instr),
    .id_pc(b_id_pc), .id_pc_plus4(b_id_pc_plus4), .bubble_cnt(b_bubble)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_id_valid); end
    checks++; if (a_if_ready !== 1'b1) begin errors++; $display("FAIL rst_if_ready got %b want 1", a_if_ready); end
    checks++; if (a_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", a_id_instr); end
    checks++; if (a_id_pc !== 32'h0 || a_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc got %h/%h want 0/0", a_id_pc, a_id_pc_plus4); end
    checks++; if (a_bubble !== 16'd0) begin errors++; $display("FAIL rst_bubble got %0d want 0", a_bubble); end
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    checks++; if (a_bubble !== 16'd3) begin errors++; $display("FAIL idle_bubble got %0d want 3", a_bubble); end
  endtask

  task automatic test_streaming();
    logic [31:0] p;
    logic [15:0] frozen;
    a_id_ready = 1'b1;
    a_if_valid = 1'b1;
    frozen = '0;
    for (int i = 0; i < 6; i++) begin
      p = 32'h100 + 32'(4 * i);
      a_if_pc = p;
      a_if_instr = p ^ 32'hA5A5_0000;
      checks++; if (a_if_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, a_if_ready); end
      step();
      if (i == 0) frozen = a_bubble;
      checks++; if (a_id_valid !== 1'b1 || a_id_pc !== p) begin errors++; $display("FAIL stream_pc[%0d] got v=%b %h want v=1 %h", i, a_id_valid, a_id_pc, p); end
      checks++; if (a_id_pc_plus4 !== p + 32'd4 || a_id_instr !== (p ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_data[%0d] got %h/%h want %h/%h", i, a_id_pc_plus4, a_id_instr, p + 32'd4, p ^ 32'hA5A5_0000); end
    end
    checks++; if (a_bubble !== frozen) begin errors++; $display("FAIL stream_bubble got %0d want %0d", a_bubble, frozen); end
    a_if_valid = 1'b0;
    step();
    checks++; if (a_id_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", a_id_valid); end
  endtask

  task automatic test_stall();
    a_id_ready = 1'b0;
    a_if_valid = 1'b1;
    a_if_pc = 32'h200; a_if_instr = 32'h1111_0200;
    step();
    checks++; if (a_if_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 got %b want 1", a_if_ready); end
    a_if_pc = 32'h204; a_if_instr = 32'h1111_0204;
    step();
    checks++; if (a_if_ready !== 1'b0) begin errors++; $display("FAIL stall_ready2 got %b want 0", a_if_ready); end
    a_if_pc = 32'h208; a_if_instr = 32'h1111_0208;
    step();
    checks++; if (a_id_valid !== 1'b1 || a_id_pc !== 32'h200 || a_if_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got v=%b pc=%h rdy=%b want v=1 pc=200 rdy=0", a_id_valid, a_id_pc, a_if_ready); end
    a_id_ready = 1'b1;
    step();
    checks++; if (a_id_pc !== 32'h204 || a_id_instr !== 32'h1111_0204 || a_id_pc_plus4 !== 32'h208) begin errors++; $display("FAIL stall_second got %h/%h/%h want 204/11110204/208", a_id_pc, a_id_instr, a_id_pc_plus4); end
    step();
    checks++; if (a_id_valid !== 1'b1 || a_id_pc !== 32'h208) begin errors++; $display("FAIL stall_third got v=%b %h want v=1 208", a_id_valid, a_id_pc); end
    a_if_valid = 1'b0;
    step();
    checks++; if (a_id_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", a_id_valid); end
  endtask

  task automatic test_flush();
    a_id_ready = 1'b0;
    a_if_valid = 1'b1;
    a_if_pc = 32'h300; a_if_instr = 32'h2222_0300;
    step();
    a_if_pc = 32'h304; a_if_instr = 32'h2222_0304;
    step();
    a_if_pc = 32'h308; a_if_instr = 32'h2222_0308;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_if_valid = 1'b0;
    checks++; if (a_id_valid !== 1'b0 || a_id_instr !== 32'h0 || a_id_pc !== 32'h0) begin errors++; $display("FAIL flush_out got v=%b %h %h want v=0 0 0", a_id_valid, a_id_instr, a_id_pc); end
    checks++; if (a_if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", a_if_ready); end
    a_id_ready = 1'b1;
    step(); step();
    checks++; if (a_id_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got v=%b pc=%h want v=0", a_id_valid, a_id_pc); end
  endtask

  task automatic test_wrap();
    a_id_ready = 1'b1;
    a_if_valid = 1'b1;
    a_if_pc = 32'hFFFF_FFFC; a_if_instr = 32'h3333_FFFC;
    step();
    a_if_valid = 1'b0;
    checks++; if (a_id_pc !== 32'hFFFF_FFFC || a_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap got %h/%h want fffffffc/00000000", a_id_pc, a_id_pc_plus4); end
    step();
  endtask

  task automatic test_reset_midstream();
    a_id_ready = 1'b0;
    a_if_valid = 1'b1;
    a_if_pc = 32'h400; a_if_instr = 32'h4444_0400;
    step();
    a_if_pc = 32'h404; a_if_instr = 32'h4444_0404;
    step();
    checks++; if (a_if_ready !== 1'b0 || a_id_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_two got rdy=%b v=%b want 0/1", a_if_ready, a_id_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_id_valid !== 1'b0 || a_id_instr !== 32'h0 || a_if_ready !== 1'b1) begin errors++; $display("FAIL async_reset got v=%b %h rdy=%b want 0 0 1", a_id_valid, a_id_instr, a_if_ready); end
    checks++; if (a_bubble !== 16'd0) begin errors++; $display("FAIL async_reset_bubble got %0d want 0", a_bubble); end
    a_if_valid = 1'b0;
    step();
    reset = 1'b0;
    a_id_ready = 1'b1;
    step();
    checks++; if (a_id_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", a_id_valid); end
  endtask

  task automatic test_noskid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (b_bubble !== 2'd0) begin errors++; $display("FAIL b_bubble_rst got %0d want 0", b_bubble); end
    repeat (5) step();
    checks++; if (b_bubble !== 2'd3) begin errors++; $display("FAIL b_bubble_sat got %0d want 3", b_bubble); end
    b_id_ready = 1'b0;
    b_if_valid = 1'b1;
    b_if_pc = 32'h500; b_if_instr = 32'h5555_0500;
    #1;
    checks++; if (b_if_ready !== 1'b1) begin errors++; $display("FAIL b_ready_empty got %b want 1", b_if_ready); end
    step();
    checks++; if (b_id_valid !== 1'b1 || b_id_pc !== 32'h500 || b_if_ready !== 1'b0) begin errors++; $display("FAIL b_full got v=%b %h rdy=%b want 1 500 0", b_id_valid, b_id_pc, b_if_ready); end
    b_id_ready = 1'b1;
    b_if_pc = 32'h504; b_if_instr = 32'h5555_0504;
    #1;
    checks++; if (b_if_ready !== 1'b1) begin errors++; $display("FAIL b_ready_follow_hi got %b want 1", b_if_ready); end
    step();
    checks++; if (b_id_pc !== 32'h504 || b_id_pc_plus4 !== 32'h508 || b_id_instr !== 32'h5555_0504) begin errors++; $display("FAIL b_refill got %h/%h/%h want 504/508/55550504", b_id_pc, b_id_pc_plus4, b_id_instr); end
    b_id_ready = 1'b0;
    b_if_pc = 32'h508;
    #1;
    checks++; if (b_if_ready !== 1'b0) begin errors++; $display("FAIL b_ready_follow_lo got %b want 0", b_if_ready); end
    step();
    checks++; if (b_id_valid !== 1'b1 || b_id_pc !== 32'h504) begin errors++; $display("FAIL b_stall_hold got v=%b %h want 1 504", b_id_valid, b_id_pc); end
    checks++; if (b_bubble !== 2'd3) begin errors++; $display("FAIL b_bubble_hold got %0d want 3", b_bubble); end
    b_if_valid = 1'b0;
    b_id_ready = 1'b1;
    step();
    checks++; if (b_id_valid !== 1'b0 || b_id_instr !== 32'h0) begin errors++; $display("FAIL b_drain got v=%b %h want 0 0", b_id_valid, b_id_instr); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_midstream();
    test_noskid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
